dram_write_collector: RTL and testbench

Sink for the SIMD pipeline's `dramwd` stream. It accepts one vector beat per handshake and pairs each beat with a write address and byte-lane mask from the address-generation side. It emits the merged write on the DRAM write port and signals completion once a configured number of beats per tile has been issued. It sits between the ALU pipeline's DRAM-write output and the tile's DRAM write arbiter.

---
 rtl/TauCfg.sv | 6 +
 rtl/dram_write_collector_pkg.sv | 4 +
 rtl/rdyack_fifo2.sv | 56 +++++
 rtl/dram_write_collector.sv | 138 +++++++++++++
 tb/tb_dram_write_collector.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/TauCfg.sv
// Tile-wide configuration shared by SIMD-side blocks: vector shape and global address width.
package TauCfg;
    localparam int VECTOR_SIZE    = 4;
    localparam int DATA_BW        = 8;
    localparam int GLOBAL_ADDR_BW = 16;
endpackage

// File: rtl/dram_write_collector_pkg.sv
// Collector-local defaults; vector and address geometry come from TauCfg.
package dram_write_collector_pkg;
    localparam int NBEAT_BW_DEFAULT = 16;
endpackage

// File: rtl/rdyack_fifo2.sv
// Two-entry FIFO with a registered head slot and full/empty flags.
// Push and pop in the same cycle are legal when not full; a full FIFO never passes data through.
module rdyack_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    logic [1:0]   cnt_r;
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full      = (cnt_r == 2'd2);
    assign empty     = (cnt_r == 2'd0);
    assign head      = head_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // occupancy and storage update; slot head_r always holds the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 2'd0;
            head_r <= '0;
            tail_r <= '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        head_r <= push_data;
                    end else begin
                        tail_r <= push_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    head_r <= tail_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    head_r <= push_data;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end
endmodule

// File: rtl/dram_write_collector.sv
// Pairs SIMD write-data beats with address/mask beats and issues merged DRAM writes,
// pulsing o_done_dval once the configured number of beats for the tile has been written.
module dram_write_collector
    import dram_write_collector_pkg::*;
#(
    parameter int VSIZE    = TauCfg::VECTOR_SIZE,
    parameter int DBW      = TauCfg::DATA_BW,
    parameter int GBW      = TauCfg::GLOBAL_ADDR_BW,
    parameter int NBEAT_BW = NBEAT_BW_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cfg_rdy,
    output logic                 o_cfg_ack,
    input  logic [NBEAT_BW-1:0]  i_cfg_nbeat,
    input  logic                 i_dramwd_rdy,
    output logic                 o_dramwd_ack,
    input  logic [VSIZE*DBW-1:0] i_dramwd,
    input  logic                 i_waddr_rdy,
    output logic                 o_waddr_ack,
    input  logic [GBW-1:0]       i_waddr,
    input  logic [VSIZE-1:0]     i_wmask,
    output logic                 o_dw_rdy,
    input  logic                 i_dw_ack,
    output logic [GBW-1:0]       o_dw_addr,
    output logic [VSIZE*DBW-1:0] o_dw_data,
    output logic [VSIZE-1:0]     o_dw_mask,
    output logic                 o_done_dval
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [NBEAT_BW-1:0] CNT_ONE = {{(NBEAT_BW-1){1'b0}}, 1'b1};

    state_e                 state_r;
    logic [NBEAT_BW-1:0]    nbeat_r;
    logic [NBEAT_BW-1:0]    d_cnt_r;
    logic [NBEAT_BW-1:0]    a_cnt_r;
    logic [NBEAT_BW-1:0]    w_cnt_r;
    logic [NBEAT_BW-1:0]    w_cnt_nxt_s;
    logic                   d_full_s;
    logic                   d_empty_s;
    logic                   a_full_s;
    logic                   a_empty_s;
    logic [GBW+VSIZE-1:0]   a_head_s;
    logic                   run_s;
    logic                   cfg_fire_s;
    logic                   d_push_s;
    logic                   a_push_s;
    logic                   w_fire_s;

    // Reset gates every handshake so nothing transfers on the reset cycle itself.
    assign run_s        = (state_r == ST_RUN) && !i_rst;
    assign o_cfg_ack    = (state_r == ST_IDLE) && !i_rst && i_cfg_rdy;
    assign o_dramwd_ack = run_s && !d_full_s && (d_cnt_r < nbeat_r);
    assign o_waddr_ack  = run_s && !a_full_s && (a_cnt_r < nbeat_r);
    assign o_dw_rdy     = !i_rst && !d_empty_s && !a_empty_s;

    assign cfg_fire_s   = i_cfg_rdy && o_cfg_ack;
    assign d_push_s     = i_dramwd_rdy && o_dramwd_ack;
    assign a_push_s     = i_waddr_rdy && o_waddr_ack;
    assign w_fire_s     = o_dw_rdy && i_dw_ack;
    assign w_cnt_nxt_s  = w_fire_s ? (w_cnt_r + CNT_ONE) : w_cnt_r;

    assign o_dw_addr    = a_head_s[GBW+VSIZE-1:VSIZE];
    assign o_dw_mask    = a_head_s[VSIZE-1:0];

    rdyack_fifo2 #(.W(VSIZE*DBW)) u_data_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (d_push_s),
        .push_data (i_dramwd),
        .pop       (w_fire_s),
        .head      (o_dw_data),
        .full      (d_full_s),
        .empty     (d_empty_s)
    );

    rdyack_fifo2 #(.W(GBW+VSIZE)) u_addr_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (a_push_s),
        .push_data ({i_waddr, i_wmask}),
        .pop       (w_fire_s),
        .head      (a_head_s),
        .full      (a_full_s),
        .empty     (a_empty_s)
    );

    // tile sequencing, beat counters and the registered done pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            nbeat_r     <= '0;
            d_cnt_r     <= '0;
            a_cnt_r     <= '0;
            w_cnt_r     <= '0;
            o_done_dval <= 1'b0;
        end else begin
            o_done_dval <= 1'b0;
            if (d_push_s) begin
                d_cnt_r <= d_cnt_r + CNT_ONE;
            end
            if (a_push_s) begin
                a_cnt_r <= a_cnt_r + CNT_ONE;
            end
            w_cnt_r <= w_cnt_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_fire_s) begin
                        nbeat_r <= i_cfg_nbeat;
                        d_cnt_r <= '0;
                        a_cnt_r <= '0;
                        w_cnt_r <= '0;
                        state_r <= ST_RUN;
                    end
                end
                // Once nbeat writes are issued both FIFOs are necessarily drained,
                // so deciding on the post-write count lands done one cycle after the last write.
                ST_RUN: begin
                    if (w_cnt_nxt_s == nbeat_r) begin
                        state_r     <= ST_DONE;
                        o_done_dval <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_write_collector.sv
// Directed bench for dram_write_collector: cycle-stepped sources and sink, with
// each tile's write log and per-cycle handshake trace checked against hand-derived values.
module tb_dram_write_collector;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cfg_rdy;
    logic        o_cfg_ack;
    logic [15:0] i_cfg_nbeat;
    logic        i_dramwd_rdy;
    logic        o_dramwd_ack;
    logic [31:0] i_dramwd;
    logic        i_waddr_rdy;
    logic        o_waddr_ack;
    logic [15:0] i_waddr;
    logic [3:0]  i_wmask;
    logic        o_dw_rdy;
    logic        i_dw_ack;
    logic [15:0] o_dw_addr;
    logic [31:0] o_dw_data;
    logic [3:0]  o_dw_mask;
    logic        o_done_dval;

    always #5 i_clk = ~i_clk;

    dram_write_collector #(.VSIZE(4), .DBW(8), .GBW(16), .NBEAT_BW(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cfg_rdy    (i_cfg_rdy),
        .o_cfg_ack    (o_cfg_ack),
        .i_cfg_nbeat  (i_cfg_nbeat),
        .i_dramwd_rdy (i_dramwd_rdy),
        .o_dramwd_ack (o_dramwd_ack),
        .i_dramwd     (i_dramwd),
        .i_waddr_rdy  (i_waddr_rdy),
        .o_waddr_ack  (o_waddr_ack),
        .i_waddr      (i_waddr),
        .i_wmask      (i_wmask),
        .o_dw_rdy     (o_dw_rdy),
        .i_dw_ack     (i_dw_ack),
        .o_dw_addr    (o_dw_addr),
        .o_dw_data    (o_dw_data),
        .o_dw_mask    (o_dw_mask),
        .o_done_dval  (o_done_dval)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0, d1;
    int base, d_idx, a_idx, d_start, a_start, d_total, a_total;
    int stall_lo, stall_hi;
    int done_cyc, cfg_cyc;

    bit          tr_cack [0:511];
    bit          tr_dack [0:511];
    bit          tr_aack [0:511];
    bit          tr_dwrdy[0:511];
    bit          tr_done [0:511];
    logic [15:0] tr_addr [0:511];
    logic [31:0] tr_data [0:511];
    logic [3:0]  tr_mask [0:511];

    int          lg_cyc[$];
    logic [15:0] lg_addr[$];
    logic [31:0] lg_data[$];
    logic [3:0]  lg_mask[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        i_dramwd_rdy = (cyc >= d_start) && (d_idx < d_total);
        i_dramwd     = 32'hA0A0_0000 + 32'(base + d_idx);
        i_waddr_rdy  = (cyc >= a_start) && (a_idx < a_total);
        i_waddr      = 16'h0100 + 16'(base + a_idx);
        i_wmask      = 4'hF ^ 4'(base + a_idx);
        i_dw_ack     = !((cyc >= stall_lo) && (cyc < stall_hi));
    endtask

    // Sample at the falling edge, then advance sources after the rising edge.
    task automatic cycle();
        logic cfg_f, d_f, a_f, w_f, dn;
        @(negedge i_clk);
        cfg_f = i_cfg_rdy && o_cfg_ack;
        d_f   = i_dramwd_rdy && o_dramwd_ack;
        a_f   = i_waddr_rdy && o_waddr_ack;
        w_f   = o_dw_rdy && i_dw_ack;
        dn    = o_done_dval;
        tr_cack[cyc]  = o_cfg_ack;
        tr_dack[cyc]  = o_dramwd_ack;
        tr_aack[cyc]  = o_waddr_ack;
        tr_dwrdy[cyc] = o_dw_rdy;
        tr_done[cyc]  = o_done_dval;
        tr_addr[cyc]  = o_dw_addr;
        tr_data[cyc]  = o_dw_data;
        tr_mask[cyc]  = o_dw_mask;
        if (w_f) begin
            lg_cyc.push_back(cyc);
            lg_addr.push_back(o_dw_addr);
            lg_data.push_back(o_dw_data);
            lg_mask.push_back(o_dw_mask);
        end
        if (cfg_f) cfg_cyc = cyc;
        if (dn) done_cyc = cyc;
        @(posedge i_clk);
        #1;
        cyc++;
        if (cfg_f) i_cfg_rdy = 1'b0;
        if (d_f) d_idx++;
        if (a_f) a_idx++;
        if (dn) begin
            d_total = 0;
            a_total = 0;
        end
        drive_inputs();
    endtask

    task automatic start_tile(input int nb, input int b, input int d_off, input int a_off,
                              input int d_tot, input int a_tot, input int s_off, input int s_len);
        c0 = cyc;
        i_cfg_rdy = 1'b1;
        i_cfg_nbeat = 16'(nb);
        base = b;
        d_idx = 0;
        a_idx = 0;
        d_start = cyc + d_off;
        a_start = cyc + a_off;
        d_total = d_tot;
        a_total = a_tot;
        stall_lo = cyc + s_off;
        stall_hi = cyc + s_off + s_len;
        done_cyc = -1;
        cfg_cyc = -1;
        lg_cyc.delete();
        lg_addr.delete();
        lg_data.delete();
        lg_mask.delete();
        drive_inputs();
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && done_cyc < 0; i++) cycle();
        check_val({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    endtask

    task automatic check_tile(input string tag, input int n);
        check_val({tag, "_count"}, 64'(lg_addr.size()), 64'(n));
        for (int i = 0; i < lg_addr.size(); i++) begin
            check_val({tag, "_addr"}, 64'(lg_addr[i]), 64'(16'h0100 + 16'(base + i)));
            check_val({tag, "_data"}, 64'(lg_data[i]), 64'(32'hA0A0_0000 + 32'(base + i)));
            check_val({tag, "_mask"}, 64'(lg_mask[i]), 64'(4'hF ^ 4'(base + i)));
        end
        if (lg_cyc.size() > 0)
            check_val({tag, "_done_cyc"}, 64'(done_cyc), 64'(lg_cyc[lg_cyc.size()-1] + 1));
    endtask

    initial begin
        i_rst = 1'b1;
        i_cfg_rdy = 1'b1;
        i_cfg_nbeat = 16'd3;
        base = 0; d_idx = 0; a_idx = 0; d_start = 0; a_start = 0;
        d_total = 0; a_total = 0; stall_lo = 0; stall_hi = 0;
        done_cyc = -1; cfg_cyc = -1;
        drive_inputs();

        // reset state, with a cfg request held during reset
        cycle();
        cycle();
        check_val("rst_cfg_ack", 64'(tr_cack[1]), 64'd0);
        check_val("rst_dramwd_ack", 64'(tr_dack[1]), 64'd0);
        check_val("rst_waddr_ack", 64'(tr_aack[1]), 64'd0);
        check_val("rst_dw_rdy", 64'(tr_dwrdy[1]), 64'd0);
        check_val("rst_done", 64'(tr_done[1]), 64'd0);
        check_val("rst_dw_addr", 64'(tr_addr[1]), 64'd0);
        check_val("rst_dw_data", 64'(tr_data[1]), 64'd0);
        check_val("rst_dw_mask", 64'(tr_mask[1]), 64'd0);
        i_rst = 1'b0;
        i_cfg_rdy = 1'b0;
        cycle();

        // nbeat=4, full streaming: writes at c0+2..c0+5, done at c0+6
        start_tile(4, 'h00, 0, 0, 4, 4, 0, 0);
        wait_done("t1", 40);
        check_val("t1_cfg_cyc", 64'(cfg_cyc), 64'(c0));
        check_tile("t1", 4);
        for (int i = 0; i < lg_cyc.size(); i++)
            check_val("t1_wr_cyc", 64'(lg_cyc[i]), 64'(c0 + 2 + i));
        check_val("t1_done_abs", 64'(done_cyc), 64'(c0 + 6));

        // nbeat=3, addresses two cycles behind data: data FIFO fills at c0+3
        start_tile(3, 'h10, 0, 3, 3, 3, 0, 0);
        wait_done("t2", 40);
        check_val("t2_dack_c1", 64'(tr_dack[c0 + 1]), 64'd1);
        check_val("t2_dack_c2", 64'(tr_dack[c0 + 2]), 64'd1);
        check_val("t2_dack_full", 64'(tr_dack[c0 + 3]), 64'd0);
        check_tile("t2", 3);
        for (int i = 0; i < lg_cyc.size(); i++)
            check_val("t2_wr_cyc", 64'(lg_cyc[i]), 64'(c0 + 4 + i));

        // nbeat=6, dw_ack low for c0+3..c0+7 while beat 1 sits at the head
        start_tile(6, 'h30, 0, 0, 6, 6, 3, 5);
        wait_done("t3", 60);
        for (int k = 3; k <= 7; k++) begin
            check_val("t3_stall_rdy", 64'(tr_dwrdy[c0 + k]), 64'd1);
            check_val("t3_stall_addr", 64'(tr_addr[c0 + k]), 64'h0131);
            check_val("t3_stall_data", 64'(tr_data[c0 + k]), 64'hA0A0_0031);
        end
        check_val("t3_full_dack", 64'(tr_dack[c0 + 5]), 64'd0);
        check_val("t3_full_aack", 64'(tr_aack[c0 + 5]), 64'd0);
        check_tile("t3", 6);
        check_val("t3_done_abs", 64'(done_cyc), 64'(c0 + 13));

        // nbeat=0 with beats on offer: no acks, done two cycles after cfg
        start_tile(0, 'h60, 0, 0, 2, 2, 0, 0);
        wait_done("t4", 20);
        check_val("t4_cfg_cyc", 64'(cfg_cyc), 64'(c0));
        check_val("t4_done_abs", 64'(done_cyc), 64'(c0 + 2));
        check_val("t4_d_acked", 64'(d_idx), 64'd0);
        check_val("t4_a_acked", 64'(a_idx), 64'd0);
        check_val("t4_count", 64'(lg_addr.size()), 64'd0);

        // nbeat=4 with a 5th data beat, next cfg requested early
        start_tile(4, 'h20, 0, 0, 5, 4, 0, 0);
        cycle();
        check_val("t5_cfg_cyc", 64'(cfg_cyc), 64'(c0));
        i_cfg_rdy = 1'b1;
        i_cfg_nbeat = 16'd0;
        wait_done("t5", 40);
        d1 = done_cyc;
        check_val("t5_done_abs", 64'(d1), 64'(c0 + 6));
        check_val("t5_d_acked", 64'(d_idx), 64'd4);
        check_tile("t5", 4);
        done_cyc = -1;
        wait_done("t5b", 20);
        check_val("t5_next_cfg", 64'(cfg_cyc), 64'(d1 + 1));
        check_val("t5b_done_abs", 64'(done_cyc), 64'(cfg_cyc + 2));

        // reset with two beats buffered and dw_ack raised on the reset cycle
        start_tile(4, 'h50, 0, 0, 4, 4, 0, 3);
        cycle();
        cycle();
        cycle();
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        d_total = 0;
        a_total = 0;
        drive_inputs();
        cycle();
        check_val("t6_dack_c1", 64'(tr_dack[c0 + 1]), 64'd1);
        check_val("t6_dack_c2", 64'(tr_dack[c0 + 2]), 64'd1);
        check_val("t6_rdy_before", 64'(tr_dwrdy[c0 + 2]), 64'd1);
        check_val("t6_rst_dw_rdy", 64'(tr_dwrdy[c0 + 3]), 64'd0);
        check_val("t6_rst_dack", 64'(tr_dack[c0 + 3]), 64'd0);
        check_val("t6_rst_aack", 64'(tr_aack[c0 + 3]), 64'd0);
        check_val("t6_post_dw_rdy", 64'(tr_dwrdy[c0 + 4]), 64'd0);
        check_val("t6_post_dack", 64'(tr_dack[c0 + 4]), 64'd0);
        check_val("t6_post_aack", 64'(tr_aack[c0 + 4]), 64'd0);
        check_val("t6_post_addr", 64'(tr_addr[c0 + 4]), 64'd0);
        check_val("t6_no_write", 64'(lg_addr.size()), 64'd0);

        // fresh nbeat=1 tile after the mid-tile reset
        start_tile(1, 'h40, 0, 0, 1, 1, 0, 0);
        wait_done("t7", 20);
        check_tile("t7", 1);
        check_val("t7_done_abs", 64'(done_cyc), 64'(c0 + 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
